// File: rtl/alu_pkg.sv
// Shared encodings for the slice-serial ALU: opcodes, compare codes, FSM states.
package alu_pkg;

    localparam logic [2:0] OP_ADD      = 3'b000;
    localparam logic [2:0] OP_SHR      = 3'b001;
    localparam logic [2:0] OP_POPCOUNT = 3'b010;
    localparam logic [2:0] OP_CMP      = 3'b011;
    localparam logic [2:0] OP_SUB      = 3'b100;
    localparam logic [2:0] OP_ASR      = 3'b101;

    localparam logic [1:0] CMP_EQ = 2'b00;
    localparam logic [1:0] CMP_GT = 2'b01;
    localparam logic [1:0] CMP_LT = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Shifts and compare walk the word from the top slice down.
    function automatic logic msb_first(input logic [2:0] op);
        return (op == OP_SHR) || (op == OP_ASR) || (op == OP_CMP);
    endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational S-bit ALU slice: add with carry, shift right with fill, popcount, compare.
module alu_slice
    import alu_pkg::*;
#(
    parameter int unsigned S  = 4,
    parameter int unsigned PW = $clog2(S + 1)
) (
    input  logic [S-1:0]  a,
    input  logic [S-1:0]  b,
    input  logic [2:0]    op,
    input  logic          chain_in,
    output logic [S-1:0]  y,
    output logic          chain_out,
    output logic [PW-1:0] pop,
    output logic          gt,
    output logic          lt
);

    always_comb begin
        y         = '0;
        chain_out = 1'b0;
        pop       = '0;
        gt        = 1'b0;
        lt        = 1'b0;
        case (op)
            OP_ADD: {chain_out, y} = (S+1)'(a) + (S+1)'(b) + (S+1)'(chain_in);
            OP_SHR: begin
                y         = {chain_in, a[S-1:1]};
                chain_out = a[0];
            end
            OP_POPCOUNT: begin
                for (int i = 0; i < int'(S); i++) begin
                    pop = pop + PW'(a[i]);
                end
            end
            OP_CMP: begin
                gt = (a > b);
                lt = (a < b);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/alu_slice_seq.sv
// Slice-serial W-bit ALU: one S-bit slice per clock, carry/shift/compare chained
// through registers, fixed N-cycle latency, valid/ready on both sides.
module alu_slice_seq
    import alu_pkg::*;
#(
    parameter int unsigned W = 32,
    parameter int unsigned S = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic [2:0]   op,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] result,
    output logic         carry,
    output logic [1:0]   cmp,
    output logic         err
);

    localparam int unsigned N   = W / S;
    localparam int unsigned CW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PW  = $clog2(W + 1);
    localparam int unsigned SPW = $clog2(S + 1);

    state_e         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [2:0]     op_q, op_d;
    logic [CW-1:0]  idx_q, idx_d;
    logic           chain_q, chain_d;
    logic [PW-1:0]  pop_q, pop_d;
    logic [1:0]     dec_q, dec_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;
    logic [W-1:0]   result_q, result_d;
    logic           carry_q, carry_d;
    logic [1:0]     cmp_q, cmp_d;
    logic           err_q, err_d;

    logic [S-1:0]   sl_a, sl_b, sl_y;
    logic [2:0]     sl_op;
    logic           sl_chain_out, sl_gt, sl_lt;
    logic [SPW-1:0] sl_pop;
    logic           last_c;

    // Operand conditioning: SUB is ADD of ~b with seed 1, ASR is SHR with sign seed.
    always_comb begin
        int unsigned base;
        base  = 32'(idx_q) * S;
        sl_a  = a_q[base +: S];
        sl_b  = (op_q == OP_SUB) ? ~b_q[base +: S] : b_q[base +: S];
        sl_op = op_q;
        if (op_q == OP_SUB) sl_op = OP_ADD;
        if (op_q == OP_ASR) sl_op = OP_SHR;
        last_c = msb_first(op_q) ? (idx_q == '0) : (idx_q == CW'(N - 1));
    end

    alu_slice #(.S(S), .PW(SPW)) u_slice (
        .a         (sl_a),
        .b         (sl_b),
        .op        (sl_op),
        .chain_in  (chain_q),
        .y         (sl_y),
        .chain_out (sl_chain_out),
        .pop       (sl_pop),
        .gt        (sl_gt),
        .lt        (sl_lt)
    );

    always_comb begin
        int unsigned base;
        state_d     = state_q;
        a_d         = a_q;
        b_d         = b_q;
        op_d        = op_q;
        idx_d       = idx_q;
        chain_d     = chain_q;
        pop_d       = pop_q;
        dec_d       = dec_q;
        res_d       = res_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        carry_d     = carry_q;
        cmp_d       = cmp_q;
        err_d       = err_q;
        base        = 32'(idx_q) * S;

        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    a_d        = a;
                    b_d        = b;
                    op_d       = op;
                    idx_d      = msb_first(op) ? CW'(N - 1) : '0;
                    chain_d    = (op == OP_SUB) || ((op == OP_ASR) && a[W-1]);
                    pop_d      = '0;
                    dec_d      = CMP_EQ;
                    res_d      = '0;
                    in_ready_d = 1'b0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                res_d[base +: S] = sl_y;
                chain_d          = sl_chain_out;
                pop_d            = pop_q + PW'(sl_pop);
                // First differing slice from the top decides the compare.
                if (dec_q == CMP_EQ) begin
                    if (sl_gt)      dec_d = CMP_GT;
                    else if (sl_lt) dec_d = CMP_LT;
                end
                if (last_c) begin
                    state_d     = ST_DONE;
                    out_valid_d = 1'b1;
                    result_d    = '0;
                    carry_d     = 1'b0;
                    cmp_d       = CMP_EQ;
                    err_d       = 1'b0;
                    case (op_q)
                        OP_ADD, OP_SUB, OP_SHR, OP_ASR: begin
                            result_d = res_d;
                            carry_d  = sl_chain_out;
                        end
                        OP_POPCOUNT: result_d = W'(pop_d);
                        OP_CMP:      cmp_d    = dec_d;
                        default:     err_d    = 1'b1;
                    endcase
                end else if (msb_first(op_q)) begin
                    idx_d = idx_q - CW'(1);
                end else begin
                    idx_d = idx_q + CW'(1);
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = ST_IDLE;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                in_ready_d = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            a_q         <= '0;
            b_q         <= '0;
            op_q        <= '0;
            idx_q       <= '0;
            chain_q     <= 1'b0;
            pop_q       <= '0;
            dec_q       <= CMP_EQ;
            res_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            carry_q     <= 1'b0;
            cmp_q       <= CMP_EQ;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_q        <= op_d;
            idx_q       <= idx_d;
            chain_q     <= chain_d;
            pop_q       <= pop_d;
            dec_q       <= dec_d;
            res_q       <= res_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            carry_q     <= carry_d;
            cmp_q       <= cmp_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;
    assign carry     = carry_q;
    assign cmp       = cmp_q;
    assign err       = err_q;

endmodule
